// File: rtl/boton_ajuste_ctrl.sv
// rtl/boton_ajuste_ctrl.sv - sync/debounce of up/down adjust buttons into one-cycle step strobes
// Auto-repeat while held is built only when BOTON_AUTOREPEAT_EN is defined.
module boton_ajuste_ctrl #(
  parameter int CNT_W       = 26,
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REP_CYCLES  = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic edit_en,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic EN
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (longint'(DEB_CYCLES) >= CNT_LIM) begin : g_deb_w
    $error("DEB_CYCLES does not fit in CNT_W bits");
  end
  if (longint'(HOLD_CYCLES) >= CNT_LIM) begin : g_hold_w
    $error("HOLD_CYCLES does not fit in CNT_W bits");
  end
  if (longint'(REP_CYCLES) >= CNT_LIM) begin : g_rep_w
    $error("REP_CYCLES does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_HOLD, S_REPEAT, S_LOCK} state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]            raw;
  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  up_q, up_d, down_q, down_d, en_q, en_d;
  logic                  dir_btn, opp_btn, strobe;
`ifdef BOTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);
  logic [CNT_W-1:0]      tmr_q, tmr_d, tmr_last;
`endif

  assign raw = {btn_down, btn_up};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = ~deb_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    strobe  = 1'b0;
    dir_btn = dir_q ? deb_q[1] : deb_q[0];
    opp_btn = dir_q ? deb_q[0] : deb_q[1];
`ifdef BOTON_AUTOREPEAT_EN
    tmr_d    = tmr_q;
    tmr_last = (state_q == S_WAIT_HOLD) ? HOLD_LAST : REP_LAST;
`endif
    if (!edit_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (deb_q[0] && deb_q[1]) begin
            state_d = S_LOCK;
          end else if (deb_q[0] || deb_q[1]) begin
            strobe  = 1'b1;
            dir_d   = deb_q[1];
            state_d = S_WAIT_HOLD;
          end
        end
        S_WAIT_HOLD, S_REPEAT: begin
          // Release and opposite press win over the timer in the same cycle.
          if (!dir_btn) begin
            state_d = S_IDLE;
          end else if (opp_btn) begin
            state_d = S_LOCK;
          end
`ifdef BOTON_AUTOREPEAT_EN
          else if (tmr_q == tmr_last) begin
            strobe  = 1'b1;
            tmr_d   = '0;
            state_d = S_REPEAT;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
`endif
        end
        S_LOCK: begin
          if (!deb_q[0] && !deb_q[1]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef BOTON_AUTOREPEAT_EN
    if (state_d != state_q) tmr_d = '0;
`endif
    up_d   = strobe & ~dir_d;
    down_d = strobe &  dir_d;
    en_d   = strobe;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_cnt_q <= '0;
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      en_q      <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
      tmr_q     <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      up_q      <= up_d;
      down_q    <= down_d;
      en_q      <= en_d;
`ifdef BOTON_AUTOREPEAT_EN
      tmr_q     <= tmr_d;
`endif
    end
  end

  assign up   = up_q;
  assign down = down_q;
  assign EN   = en_q;

endmodule

// File: tb/tb_boton_ajuste_ctrl.sv
// tb/tb_boton_ajuste_ctrl.sv - scoreboard bench for boton_ajuste_ctrl against a strobe-schedule model
module tb_boton_ajuste_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rst;
  logic edit_en;
  logic btn_up;
  logic btn_down;
  logic up, down, en_out;

  boton_ajuste_ctrl #(
    .CNT_W(26), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .edit_en(edit_en), .btn_up(btn_up), .btn_down(btn_down),
    .up(up), .down(down), .EN(en_out)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit dn;} ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int strobe_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: debounced level = last DEB synchronized samples all disagree
  // with the current level; strobes scheduled by age since the first strobe.
  bit [15:0] h_u, h_d;
  bit        m_u, m_d;
  int        m_mode;   // 0 idle, 1 pressed, 2 locked
  bit        m_dir;
  int        m_age;

  function automatic bit settle(input bit [15:0] h, input bit lvl);
    for (int j = 2; j <= DEB + 1; j++) if (h[j] == lvl) return lvl;
    return !lvl;
  endfunction

  task automatic model_step(input bit u, input bit d, input bit en, input bit r,
                            output bit su, output bit sd);
    bit held, other, s;
    su = 1'b0; sd = 1'b0; s = 1'b0;
    if (!r) begin
      h_u = '0; h_d = '0; m_u = 1'b0; m_d = 1'b0; m_mode = 0; m_age = 0;
      return;
    end
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (m_u && m_d) m_mode = 2;
      else if (m_u || m_d) begin
        s = 1'b1; m_dir = m_d; m_mode = 1; m_age = 0;
      end
    end else if (m_mode == 1) begin
      held  = m_dir ? m_d : m_u;
      other = m_dir ? m_u : m_d;
      if (!held) m_mode = 0;
      else if (other) m_mode = 2;
      else begin
        m_age++;
`ifdef BOTON_AUTOREPEAT_EN
        if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0)) s = 1'b1;
`endif
      end
    end else begin
      if (!m_u && !m_d) m_mode = 0;
    end
    su = s & !m_dir;
    sd = s & m_dir;
    h_u = {h_u[14:0], u};
    h_d = {h_d[14:0], d};
    m_u = settle(h_u, m_u);
    m_d = settle(h_d, m_d);
  endtask

  task automatic drive(input bit u, input bit d, input bit en, input bit r);
    bit su, sd, prev_r;
    @(negedge clk);
    prev_r   = rst;
    btn_up   = u;
    btn_down = d;
    edit_en  = en;
    rst      = r;
    if (prev_r && !r) begin
      #1;
      total++;
      if (up !== 1'b0 || down !== 1'b0 || en_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_drop up=%0b down=%0b EN=%0b required=0", up, down, en_out);
      end
    end
    model_step(u, d, en, r, su, sd);
    if (su || sd) exp_q.push_back('{cyc: edge_cnt + 1, dn: sd});
  endtask

  task automatic run(input bit u, input bit d, input bit en, input int n);
    for (int i = 0; i < n; i++) drive(u, d, en, 1'b1);
  endtask

  task automatic expect_count(input string name, input int start, input int req);
    total++;
    if (strobe_cnt - start != req) begin
      bad++;
      $display("FAIL %s strobes=%0d required=%0d", name, strobe_cnt - start, req);
    end
  endtask

  always @(posedge clk) begin
    ev_t ev;
    #1;
    total++;
    if ((up & down) !== 1'b0 || en_out !== (up | down)) begin
      bad++;
      $display("FAIL exclusive cycle=%0d up=%0b down=%0b EN=%0b", edge_cnt, up, down, en_out);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
      ev = exp_q.pop_front();
      total++; bad++;
      $display("FAIL strobe_missing cycle=%0d got=none required_dir=%0b", ev.cyc, ev.dn);
    end
    if (up === 1'b1 || down === 1'b1) begin
      strobe_cnt++;
      total++;
      if (exp_q.size() == 0 || exp_q[0].cyc != edge_cnt) begin
        bad++;
        $display("FAIL strobe_unexpected cycle=%0d up=%0b down=%0b required=none", edge_cnt, up, down);
      end else begin
        ev = exp_q.pop_front();
        if (down !== ev.dn) begin
          bad++;
          $display("FAIL strobe_dir cycle=%0d down=%0b required=%0b", edge_cnt, down, ev.dn);
        end
      end
    end
  end

  initial begin
    int s;
    bit cu, cd, cen, cr;
    rst = 1'b0; edit_en = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (up !== 1'b0 || down !== 1'b0 || en_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state up=%0b down=%0b EN=%0b required=0", up, down, en_out);
    end
    run(0, 0, 1, 10);

    s = strobe_cnt; run(1, 0, 1, 12); run(0, 0, 1, 12);
    expect_count("clean_press", s, 1);

    s = strobe_cnt;
    for (int i = 0; i < 10; i++) drive(1'b0, ((i / 2) % 2) == 0, 1'b1, 1'b1);
    run(0, 1, 1, 12); run(0, 0, 1, 12);
    expect_count("bounce", s, 1);

    s = strobe_cnt; run(1, 0, 1, 60); run(0, 0, 1, 14);
`ifdef BOTON_AUTOREPEAT_EN
    expect_count("auto_repeat", s, 6);
`else
    expect_count("single_per_press", s, 1);
`endif

    s = strobe_cnt; run(1, 1, 1, 30);
    expect_count("both_lock", s, 0);
    s = strobe_cnt; run(1, 0, 1, 12); run(0, 0, 1, 12);
    expect_count("lock_release_down", s, 0);
    s = strobe_cnt; run(1, 0, 1, 12); run(0, 0, 1, 12);
    expect_count("after_lock_press", s, 1);

    s = strobe_cnt; run(1, 0, 0, 40); run(0, 0, 0, 12);
    expect_count("edit_disabled", s, 0);
    run(0, 0, 1, 4);

    s = strobe_cnt;
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 1'b1, !(i == 14 || i == 22));
    run(0, 0, 1, 12);
    expect_count("reset_mid_hold", s, 3);

    cu = 0; cd = 0; cen = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) cu = !cu;
      if ($urandom_range(15) == 0) cd = !cd;
      if ($urandom_range(99) == 0) cen = !cen;
      cr = ($urandom_range(399) != 0);
      drive(cu, cd, cen, cr);
    end
    run(0, 0, 1, 16);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_strobes left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boton_ajuste_ctrl.md
Name: boton_ajuste_ctrl

Overview:
- Pushbutton front-end for the time/date adjust path; drives the up/down/EN inputs of the 0-99 BCD adjust counters directly.
- Synchronizes and debounces two raw buttons and emits single-cycle step pulses.
- Optionally auto-repeats the step pulse while a button is held.
- Never asserts up and down together, so the downstream counter's both-asserted state is unreachable from this block.

Parameters:
- CNT_W, 26, width of the shared debounce/hold/repeat timers.
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- HOLD_CYCLES, 50000000, cycles from the first pulse to the first auto-repeat pulse.
- REP_CYCLES, 20000000, cycles between auto-repeat pulses.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- edit_en  input  1  adjust mode active; pulses are allowed only while high.
- btn_up  input  1  raw, asynchronous, bouncy increment button.
- btn_down  input  1  raw, asynchronous, bouncy decrement button.
- up  output  1  one-cycle increment strobe.
- down  output  1  one-cycle decrement strobe.
- EN  output  1  one-cycle step enable; EN = up | down, same cycle.

Behaviour:
- Reset:
  - rst low immediately forces up=0, down=0 and EN=0.
  - It also clears both synchronizers, debounced levels and timers, and sets FSM=IDLE.
- Synchronizer: 2 flip-flops per button.
- Debounce, per button:
  - The counter increments while the sync output differs from the debounced level and clears when they match.
  - On reaching DEB_CYCLES-1, the debounced level toggles and the counter clears.
- Latency: a raw level change that stays stable produces its first strobe on rising edge DEB_CYCLES+3 after the change.
- Outputs are registered.
- FSM states: IDLE, WAIT_HOLD, REPEAT, LOCK.
  - IDLE:
    - One debounced button pressed with edit_en=1: emit a strobe for that direction, latch dir, clear timer, go to WAIT_HOLD.
    - Both pressed: go to LOCK, no strobe.
  - WAIT_HOLD:
    - Timer counts each cycle.
    - At HOLD_CYCLES-1: emit a dir strobe, clear timer, go to REPEAT.
  - REPEAT:
    - At REP_CYCLES-1: emit a dir strobe, clear timer.
  - Exits from WAIT_HOLD/REPEAT:
    - dir button released: go to IDLE.
    - Opposite button pressed: go to LOCK.
    - Checked before the timer; no strobe that cycle.
  - LOCK: no strobes; go to IDLE only when both debounced buttons are low.
- edit_en low in any state: next state IDLE, no strobe that cycle; edit_en is not debounced.
- Strobe width: exactly 1 cycle. up and down are mutually exclusive in every cycle.
- Reset mid-hold:
  - Outputs drop immediately.
  - After release of rst, a still-held button is a fresh press: first strobe DEB_CYCLES+3 edges after rst deassertion.
- Timer never wraps; it is cleared on every state entry.
- Width rule: assert in simulation that HOLD_CYCLES, REP_CYCLES and DEB_CYCLES are each < 2^CNT_W.

Optional Feature:
- Macro: BOTON_AUTOREPEAT_EN.
- Defined: WAIT_HOLD/REPEAT behaviour as above.
- Undefined:
  - WAIT_HOLD holds without timing, and REPEAT and the hold/repeat timer are not built.
  - Exactly one strobe per accepted press; releasing the dir button returns to IDLE; pressing the opposite button goes to LOCK.

Test Plan:
Bench parameters for all scenarios: DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=8, edit_en=1 unless stated; times are rising edges after the stimulus change.
- Clean press: btn_up high at edge 0 for 12 cycles -> single up=EN=1 at edge 7; down=0 throughout; no further strobes.
- Bounce: btn_down toggles every 2 cycles for 10 cycles, then stays high 12 cycles -> exactly one down/EN strobe, 7 edges after the last toggle; zero strobes during bouncing.
- Auto-repeat: btn_up held edges 0-59, macro defined -> strobes at edges 7, 27, 35, 43, 51, 59 only; none after release.
  - Same stimulus, macro undefined -> one strobe at edge 7.
- Simultaneous buttons: both high together for 30 cycles -> no strobes.
  - While in LOCK, release btn_down only -> still no strobe.
  - Release both, then a clean btn_up press -> one strobe.
  - Every scenario: assertion up & down == 0 on every cycle.
- Mode/reset:
  - edit_en=0 with btn_up held 40 cycles -> no strobes.
  - Hold btn_up and pulse rst low at edge 15 -> outputs 0 within the same cycle, without waiting for a clock edge.
  - btn_up still held -> next strobe exactly 7 edges after rst returns high.
